dual_debouncer: RTL and testbench

- Two-channel synchronizer and debouncer for asynchronous, bouncy inputs.
- Used in front of the PS/2 keyboard receiver: channel 0 carries the keyboard clock, channel 1 the keyboard data.
- Each channel is synchronized into the system clock domain.
- A channel's output changes only after its synchronized input has held a new level for a programmable number of consecutive cycles.

---
 rtl/ps2_pkg.sv | 5 +
 rtl/debounce_channel.sv | 48 ++++
 rtl/dual_debouncer.sv | 40 ++++
 tb/tb_dual_debouncer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 front end: debounce depth and idle line level.
package ps2_pkg;
  localparam int   DEBOUNCE_STABLE_COUNT_DEFAULT = 19;
  localparam logic PS2_IDLE_LEVEL                = 1'b1;
endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchronizer, stability counter and registered output.
module debounce_channel
  import ps2_pkg::*;
#(
  parameter int   STABLE_COUNT = DEBOUNCE_STABLE_COUNT_DEFAULT,
  parameter logic RESET_LEVEL  = PS2_IDLE_LEVEL,
  parameter int   CNT_W        = $clog2(STABLE_COUNT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  logic             r_sync_a;
  logic             r_sync_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             w_mismatch;

  assign w_mismatch = (r_sync_b != r_out);

  // Any return to equality clears the count, so short glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a <= RESET_LEVEL;
      r_sync_b <= RESET_LEVEL;
      r_cnt    <= '0;
      r_out    <= RESET_LEVEL;
    end else begin
      r_sync_a <= i_in;
      r_sync_b <= r_sync_a;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_out <= r_sync_b;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/dual_debouncer.sv
// Two independent debounce lanes: channel 0 is the PS/2 clock, channel 1 the PS/2 data.
module dual_debouncer
  import ps2_pkg::*;
#(
  parameter int   STABLE_COUNT = DEBOUNCE_STABLE_COUNT_DEFAULT,
  parameter logic RESET_LEVEL  = PS2_IDLE_LEVEL,
  parameter int   CNT_W        = $clog2(STABLE_COUNT)
) (
  input  logic clk,
  input  logic rst,
  input  logic In0,
  input  logic In1,
  output logic Out0,
  output logic Out1
);

  logic [1:0] w_in;
  logic [1:0] w_out;

  assign w_in = {In1, In0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      debounce_channel #(
        .STABLE_COUNT (STABLE_COUNT),
        .RESET_LEVEL  (RESET_LEVEL),
        .CNT_W        (CNT_W)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .i_in  (w_in[gi]),
        .o_out (w_out[gi])
      );
    end
  endgenerate

  assign Out0 = w_out[0];
  assign Out1 = w_out[1];

endmodule

// File: tb/tb_dual_debouncer.sv
// Directed bench for dual_debouncer with default parameters (21-edge latency).
module tb_dual_debouncer;

  logic clk;
  logic rst;
  logic in0;
  logic in1;
  logic out0;
  logic out1;

  int err_cnt = 0;
  int chk_cnt = 0;

  dual_debouncer dut (
    .clk  (clk),
    .rst  (rst),
    .In0  (in0),
    .In1  (in1),
    .Out0 (out0),
    .Out1 (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_hold(input string tag, input int n, input logic e0, input logic e1);
    for (int i = 0; i < n; i++) begin
      step(1);
      check_val({tag, "_out0"}, 32'(out0), 32'(e0));
      check_val({tag, "_out1"}, 32'(out1), 32'(e1));
    end
  endtask

  logic exp_data;

  task automatic ps2_half(input logic lvl, input logic set_data, input logic dbit);
    int   trans;
    logic prev;
    trans = 0;
    prev  = out0;
    for (int i = 0; i < 4000; i++) begin
      if (i < 5) in0 = (i % 2 == 0) ? lvl : ~lvl;
      else       in0 = lvl;
      if (set_data && i == 2000) in1 = dbit;
      step(1);
      if (out0 !== prev) begin
        trans++;
        if (out0 == 1'b0) check_val("ps2_data_at_fall", 32'(out1), 32'(exp_data));
      end
      prev = out0;
    end
    if (set_data) exp_data = dbit;
    check_val("ps2_transitions", 32'(trans), 32'd1);
    check_val("ps2_level", 32'(out0), 32'(lvl));
  endtask

  initial begin
    rst = 1'b1;
    in0 = 1'b0;
    in1 = 1'b0;

    // Reset: outputs at idle level from the first reset edge.
    step(1);
    check_val("rst_first_out0", 32'(out0), 32'd1);
    check_val("rst_first_out1", 32'(out1), 32'd1);
    expect_hold("rst_hold", 2, 1'b1, 1'b1);
    rst = 1'b0;
    expect_hold("rst_release", 20, 1'b1, 1'b1);
    expect_hold("rst_settle", 1, 1'b0, 1'b0);
    $display("reset scenario done at %0t", $time);

    // Clean edge on channel 0.
    in0 = 1'b1;
    in1 = 1'b1;
    step(25);
    check_val("clean_pre_out0", 32'(out0), 32'd1);
    check_val("clean_pre_out1", 32'(out1), 32'd1);
    in0 = 1'b0;
    expect_hold("clean_wait", 20, 1'b1, 1'b1);
    expect_hold("clean_edge", 1, 1'b0, 1'b1);
    $display("clean edge scenario done at %0t", $time);

    // Glitch of 18 synchronized cycles is rejected.
    in1 = 1'b0;
    step(18);
    in1 = 1'b1;
    expect_hold("glitch18", 25, 1'b0, 1'b1);
    // A 19-cycle pulse gets through, then recovers.
    in1 = 1'b0;
    step(19);
    in1 = 1'b1;
    expect_hold("pulse19_e19", 1, 1'b0, 1'b1);
    expect_hold("pulse19_e20", 1, 1'b0, 1'b0);
    expect_hold("pulse19_low", 18, 1'b0, 1'b0);
    expect_hold("pulse19_back", 1, 1'b0, 1'b1);
    $display("glitch scenario done at %0t", $time);

    // Opposite simultaneous transitions.
    in0 = 1'b1;
    in1 = 1'b0;
    step(25);
    check_val("indep_pre_out0", 32'(out0), 32'd1);
    check_val("indep_pre_out1", 32'(out1), 32'd0);
    in0 = 1'b0;
    in1 = 1'b1;
    expect_hold("indep_wait", 20, 1'b1, 1'b0);
    expect_hold("indep_edge", 1, 1'b0, 1'b1);
    $display("independence scenario done at %0t", $time);

    // Reset in the middle of a count restarts the full latency.
    in0 = 1'b1;
    step(25);
    check_val("midrst_pre_out0", 32'(out0), 32'd1);
    in0 = 1'b0;
    step(10);
    rst = 1'b1;
    step(1);
    check_val("midrst_in_out0", 32'(out0), 32'd1);
    check_val("midrst_in_out1", 32'(out1), 32'd1);
    rst = 1'b0;
    expect_hold("midrst_wait", 20, 1'b1, 1'b1);
    expect_hold("midrst_edge", 1, 1'b0, 1'b1);
    $display("reset mid-count scenario done at %0t", $time);

    // PS/2-rate clock with bounce; data changes mid high phase.
    in0 = 1'b1;
    in1 = 1'b1;
    step(25);
    exp_data = 1'b1;
    check_val("ps2_pre_out0", 32'(out0), 32'd1);
    ps2_half(1'b0, 1'b0, 1'b0);
    ps2_half(1'b1, 1'b1, 1'b0);
    ps2_half(1'b0, 1'b0, 1'b0);
    ps2_half(1'b1, 1'b1, 1'b1);
    ps2_half(1'b0, 1'b0, 1'b0);
    ps2_half(1'b1, 1'b1, 1'b0);
    $display("ps2 rate scenario done at %0t", $time);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
